// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encodings and counter sizing for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_adder_full_add_cell.sv
// full_add_cell: one-bit full adder built from two half-adder stages and an OR.
module full_add_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g1;
    logic g2;

    assign p    = x ^ y;
    assign g1   = x & y;
    assign s    = p ^ cin;
    assign g2   = p & cin;
    assign cout = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with valid/ready handshake and registered carry.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a-b via inverted b and carry-in of 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int CW = clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sr_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, cout_q, sub_q, sub_in;
    logic             s_bit, c_bit, last;
    logic [WIDTH-1:0] sr_d;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    full_add_cell u_cell (
        .x   (a_q[0]),
        .y   (b_q[0] ^ sub_q),
        .cin (c_q),
        .s   (s_bit),
        .cout(c_bit)
    );

    assign last = cnt_q == CW'(WIDTH - 1);
    assign sr_d = {s_bit, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = in_valid ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = last ? ST_DONE : ST_RUN;
            ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && in_valid) begin
                a_q   <= a;
                b_q   <= b;
                sub_q <= sub_in;
                c_q   <= sub_in;
                cnt_q <= '0;
            end else if (state_q == ST_RUN) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                sr_q  <= sr_d;
                c_q   <= c_bit;
                cnt_q <= cnt_q + 1'b1;
                // The visible result only updates on DONE entry so it stays stable through IDLE.
                if (last) begin
                    sum_q  <= sr_d;
                    cout_q <= c_bit;
                end
            end
        end
    end

    assign in_ready  = state_q == ST_IDLE;
    assign out_valid = state_q == ST_DONE;
    assign busy      = state_q != ST_IDLE;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table plus hand-written handshake/reset sequences.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sub_s = 1'b0;
    logic       in_ready, out_valid, carry_out, busy;
    logic [7:0] sum;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t vecs[6];

    serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub_s),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry_out(carry_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                          input logic ordy, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        a = av;
        b = bv;
        sub_s = sv;
        out_ready = ordy;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'hC3;
        b = 8'h5A;
        sub_s = ~sv;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bc, cyc, k, n;
        logic [7:0] s_cap;
        logic c_cap, ov_seen;
        int acc[3];
        logic [7:0] got[3];
        logic [7:0] op_a[3];
        logic [7:0] op_b[3];
        vecs[0] = '{8'h35, 8'h0A, 8'h3F, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'h9C, 8'h27, 8'hC3, 1'b0};
        op_a = '{8'h01, 8'h03, 8'h05};
        op_b = '{8'h02, 8'h04, 8'h06};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", carry_out, 0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("rst_no_accept", busy, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // latency and busy duration for 0x35+0x0A
        a = 8'h35;
        b = 8'h0A;
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'hFF;
        bc = 0;
        lat = -1;
        s_cap = '0;
        c_cap = 1'b0;
        while (busy && bc < 40) begin
            if (out_valid && lat < 0) begin
                lat = bc;
                s_cap = sum;
                c_cap = carry_out;
            end
            bc++;
            @(negedge clk);
        end
        chk("t1_latency", lat, 8);
        chk("t1_busy_cycles", bc, 9);
        chk("t1_sum", s_cap, 8'h3F);
        chk("t1_cout", c_cap, 0);
        chk("t1_idle_sum_hold", sum, 8'h3F);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, 1'b1, lat);
            chk($sformatf("vec%0d_latency", i), lat, 8);
            chk($sformatf("vec%0d_sum", i), sum, vecs[i].s);
            chk($sformatf("vec%0d_cout", i), carry_out, vecs[i].c);
            @(negedge clk);
            chk($sformatf("vec%0d_idle", i), in_ready, 1);
        end

        // result held in DONE with back-pressure, in_valid ignored
        run_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
        chk("t3_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            a = 8'h77;
            b = 8'h11;
            in_valid = i[0];
            @(negedge clk);
            chk("t3_sum_hold", sum, 8'h46);
            chk("t3_valid_hold", out_valid, 1);
            chk("t3_not_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_idle_after_ack", in_ready, 1);
        chk("t3_busy_after_ack", busy, 0);
        @(negedge clk);
        chk("t3_no_stray_accept", busy, 0);

        // asynchronous reset in the 4th RUN cycle
        a = 8'hAA;
        b = 8'h55;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_running", busy, 1);
        rst = 1'b1;
        #1;
        chk("t4_rst_in_ready", in_ready, 1);
        chk("t4_rst_out_valid", out_valid, 0);
        chk("t4_rst_sum", sum, 0);
        chk("t4_rst_cout", carry_out, 0);
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            ov_seen |= out_valid;
            @(negedge clk);
        end
        chk("t4_no_valid", ov_seen, 0);
        run_op(8'h10, 8'h20, 1'b0, 1'b1, lat);
        chk("t4_after_sum", sum, 8'h30);
        chk("t4_after_lat", lat, 8);
        @(negedge clk);

        // back-to-back with in_valid and out_ready held high
        cyc = 0;
        k = 0;
        n = 0;
        acc = '{0, 0, 0};
        got = '{8'h00, 8'h00, 8'h00};
        out_ready = 1'b1;
        while ((k < 3 || n < 3) && cyc < 100) begin
            in_valid = k < 3;
            if (in_ready && k < 3) begin
                a = op_a[k];
                b = op_b[k];
                acc[k] = cyc;
                k++;
            end
            if (out_valid && n < 3) begin
                got[n] = sum;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("t5_results", n, 3);
        chk("t5_ii_0", acc[1] - acc[0], 10);
        chk("t5_ii_1", acc[2] - acc[1], 10);
        chk("t5_sum0", got[0], 8'h03);
        chk("t5_sum1", got[1], 8'h07);
        chk("t5_sum2", got[2], 8'h0B);
        repeat (2) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h07, 8'h05, 1'b1, 1'b1, lat);
        chk("t6_sub_pos_sum", sum, 8'h02);
        chk("t6_sub_pos_cout", carry_out, 1);
        @(negedge clk);
        run_op(8'h05, 8'h07, 1'b1, 1'b1, lat);
        chk("t6_sub_neg_sum", sum, 8'hFE);
        chk("t6_sub_neg_cout", carry_out, 0);
        @(negedge clk);
        run_op(8'h05, 8'h07, 1'b0, 1'b1, lat);
        chk("t6_add_sum", sum, 8'h0C);
        chk("t6_add_cout", carry_out, 0);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
